rand_mem_responder: RTL and testbench

//  Memory-side responder for the single-outstanding mem_read/mem_write/mem_resp

---
 rtl/rand_mem_responder.sv | 136 +++++++++++++
 tb/tb_rand_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rand_mem_responder.sv
// Memory-side responder for the single-outstanding mem_read/mem_write/mem_resp protocol.
// Holds each accepted request for LATENCY cycles, then answers from an internal word array.
module rand_mem_responder #(
  parameter int addr_width  = 64,
  parameter int data_width  = 64,
  parameter int index_width = 8,
  parameter int LATENCY     = 2,
  parameter int cnt_width   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [addr_width-1:0] mem_addr,
  input  logic [data_width-1:0] mem_wdata,
  output logic [data_width-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic                  busy,
  output logic [cnt_width-1:0]  wr_count,
  output logic [cnt_width-1:0]  rd_count
);

  localparam int depth = 2 ** index_width;
  localparam int lat_w = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  localparam logic [lat_w-1:0]     lat_one = lat_w'(1);
  localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [lat_w-1:0]       cnt_q, cnt_d;
  logic [index_width-1:0] idx_q, idx_d;
  logic [data_width-1:0]  wdata_q, wdata_d;
  logic                   op_rd_q, op_rd_d;
  logic                   op_wr_q, op_wr_d;
  logic                   mem_resp_q, mem_resp_d;
  logic [data_width-1:0]  mem_rdata_q, mem_rdata_d;
  logic [cnt_width-1:0]   wr_count_q, wr_count_d;
  logic [cnt_width-1:0]   rd_count_q, rd_count_d;
  logic                   mem_we;
  logic [data_width-1:0]  mem_q [depth];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    op_rd_d     = op_rd_q;
    op_wr_d     = op_wr_q;
    mem_resp_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    mem_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = mem_addr[index_width-1:0];
          wdata_d = mem_wdata;
          op_rd_d = mem_read;
          op_wr_d = mem_write;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = lat_w'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == lat_one) state_d = ST_RESP;
        else                  cnt_d   = cnt_q - lat_one;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        mem_we  = op_wr_q;
        // Read+write is a write: only the write counter moves.
        if (op_wr_q) begin
          if (wr_count_q != '1) wr_count_d = wr_count_q + cnt_one;
        end else if (op_rd_q) begin
          if (rd_count_q != '1) rd_count_d = rd_count_q + cnt_one;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Response registers load on the edge entering RESP; a combined op returns pre-write data.
    if (state_d == ST_RESP) begin
      mem_resp_d = 1'b1;
      if (op_rd_d) mem_rdata_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      op_rd_q     <= 1'b0;
      op_wr_q     <= 1'b0;
      mem_resp_q  <= 1'b0;
      mem_rdata_q <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      // NOTE: clearing every word on reset forces the array into flops; a RAM macro cannot do this.
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      op_rd_q     <= op_rd_d;
      op_wr_q     <= op_wr_d;
      mem_resp_q  <= mem_resp_d;
      mem_rdata_q <= mem_rdata_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      if (mem_we) mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem_resp  = mem_resp_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

endmodule

// File: tb/tb_rand_mem_responder.sv
// Self-checking bench for rand_mem_responder: a LATENCY=2 instance and a LATENCY=1 instance
// with 3-bit counters, both compared against a word-array / counter reference model.
module tb_rand_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_read, a_write, a_resp, a_busy;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic [31:0] a_wr_count, a_rd_count;

  logic        b_read, b_write, b_resp, b_busy;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic [2:0]  b_wr_count, b_rd_count;

  rand_mem_responder #(.LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .mem_read(a_read), .mem_write(a_write), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_resp(a_resp), .busy(a_busy),
    .wr_count(a_wr_count), .rd_count(a_rd_count)
  );

  rand_mem_responder #(.LATENCY(1), .cnt_width(3)) dut_b (
    .clk(clk), .rst(rst), .mem_read(b_read), .mem_write(b_write), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_resp(b_resp), .busy(b_busy),
    .wr_count(b_wr_count), .rd_count(b_rd_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one word array, last read data and completion counts per instance.
  logic [63:0]     model_mem [2][256];
  logic [63:0]     model_last [2];
  longint unsigned model_wr [2];
  longint unsigned model_rd [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 256; i++) model_mem[b][i] = '0;
      model_last[b] = '0;
      model_wr[b]   = 0;
      model_rd[b]   = 0;
    end
  endtask

  task automatic drive(input bit b, input logic rd, input logic wr,
                       input logic [63:0] addr, input logic [63:0] wd);
    if (b) begin
      b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
    end else begin
      a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
    end
  endtask

  function automatic logic [63:0] obs_rdata(input bit b);
    return b ? b_rdata : a_rdata;
  endfunction
  function automatic logic [63:0] obs_resp(input bit b);
    return b ? {63'd0, b_resp} : {63'd0, a_resp};
  endfunction
  function automatic logic [63:0] obs_busy(input bit b);
    return b ? {63'd0, b_busy} : {63'd0, a_busy};
  endfunction
  function automatic logic [63:0] obs_wr(input bit b);
    return b ? {61'd0, b_wr_count} : {32'd0, a_wr_count};
  endfunction
  function automatic logic [63:0] obs_rd(input bit b);
    return b ? {61'd0, b_rd_count} : {32'd0, a_rd_count};
  endfunction

  function automatic string tg(input bit b, input string name);
    return $sformatf("%s_%s", b ? "lat1" : "lat2", name);
  endfunction

  // One request, called at a negedge with the instance idle. early_drop releases the
  // request after the accept edge; keep leaves it asserted after the response.
  task automatic txn(input bit b, input logic rd, input logic wr, input logic [63:0] addr,
                     input logic [63:0] wd, input bit early_drop, input bit keep);
    int              lat = b ? 1 : 2;
    logic [7:0]      idx = addr[7:0];
    longint unsigned cap = b ? 64'd7 : 64'hFFFF_FFFF;
    drive(b, rd, wr, addr, wd);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      @(negedge clk);
      check(tg(b, "busy"), obs_busy(b), 64'd1);
      check(tg(b, k == lat ? "resp" : "resp_early"), obs_resp(b), (k == lat) ? 64'd1 : 64'd0);
      if (early_drop && k == 1) drive(b, 1'b0, 1'b0, '0, '0);
    end
    if (rd) model_last[b] = model_mem[b][idx];
    check(tg(b, "rdata"), obs_rdata(b), model_last[b]);
    if (!keep) drive(b, 1'b0, 1'b0, '0, '0);
    if (wr) begin
      model_mem[b][idx] = wd;
      if (model_wr[b] < cap) model_wr[b]++;
    end else if (model_rd[b] < cap) begin
      model_rd[b]++;
    end
    @(posedge clk);
    @(negedge clk);
    check(tg(b, "resp_after"), obs_resp(b), 64'd0);
    check(tg(b, "busy_after"), obs_busy(b), 64'd0);
    check(tg(b, "rdata_hold"), obs_rdata(b), model_last[b]);
    check(tg(b, "wr_count"), obs_wr(b), model_wr[b]);
    check(tg(b, "rd_count"), obs_rd(b), model_rd[b]);
  endtask

  task automatic check_idle_outputs(input bit b);
    check(tg(b, "idle_resp"), obs_resp(b), 64'd0);
    check(tg(b, "idle_busy"), obs_busy(b), 64'd0);
    check(tg(b, "idle_rdata"), obs_rdata(b), model_last[b]);
    check(tg(b, "idle_wr_count"), obs_wr(b), model_wr[b]);
    check(tg(b, "idle_rd_count"), obs_rd(b), model_rd[b]);
  endtask

  task automatic random_txn(input bit b);
    int          op = int'($urandom_range(0, 2));
    logic [63:0] ra = {$urandom, $urandom} & ~64'h0000_0000_0000_00F0;
    logic [63:0] rw = {$urandom, $urandom};
    txn(b, op != 1, op != 0, ra, rw, bit'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs(1'b0);
    check_idle_outputs(1'b1);

    // Write, read-back, aliasing, combined read+write.
    txn(1'b0, 1'b0, 1'b1, 64'h5,   64'hDEAD, 1'b0, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 64'h5,   64'h0,    1'b0, 1'b0);
    txn(1'b0, 1'b0, 1'b1, 64'h105, 64'h1234, 1'b0, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 64'h05,  64'h0,    1'b0, 1'b0);
    txn(1'b0, 1'b0, 1'b1, 64'h7,   64'hAA,   1'b0, 1'b0);
    txn(1'b0, 1'b1, 1'b1, 64'h7,   64'hBB,   1'b0, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 64'h7,   64'h0,    1'b0, 1'b0);

    // Requests dropped right after acceptance still complete.
    txn(1'b0, 1'b0, 1'b1, 64'h20,  64'h55,   1'b1, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 64'h20,  64'h0,    1'b1, 1'b0);

    // Held request: not accepted in RESP, re-accepted in the following idle cycle.
    txn(1'b0, 1'b1, 1'b0, 64'h5,   64'h0,    1'b0, 1'b1);
    txn(1'b0, 1'b1, 1'b0, 64'h5,   64'h0,    1'b0, 1'b0);
    txn(1'b1, 1'b0, 1'b1, 64'h3,   64'h77,   1'b0, 1'b1);
    txn(1'b1, 1'b0, 1'b1, 64'h3,   64'h77,   1'b0, 1'b0);

    repeat (40) random_txn(1'b0);

    // Drive the 3-bit write counter into saturation, then mix in random traffic.
    for (int i = 0; i < 8; i++) txn(1'b1, 1'b0, 1'b1, 64'(i), {$urandom, $urandom}, 1'b0, 1'b0);
    repeat (20) random_txn(1'b1);

    // Reset while a write is waiting: no response, state and array cleared.
    drive(1'b0, 1'b0, 1'b1, 64'h5, 64'h99);
    @(posedge clk);
    @(negedge clk);
    check("lat2_busy_before_reset", obs_busy(1'b0), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      check("lat2_no_resp_after_reset", obs_resp(1'b0), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check_idle_outputs(1'b0);
    check_idle_outputs(1'b1);
    txn(1'b0, 1'b1, 1'b0, 64'h5,  64'h0,  1'b0, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 64'h7,  64'h0,  1'b0, 1'b0);
    txn(1'b0, 1'b0, 1'b1, 64'h9,  64'h42, 1'b0, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 64'h9,  64'h0,  1'b0, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 64'h3,  64'h0,  1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
